// File: rtl/v_datamem_pkg.sv
// Shared constants, lane request struct and byte-order helpers for the banked data memory.
package v_datamem_pkg;
  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int NUM_BYTES  = DATA_W / BYTE_W;
  localparam int REQ_ADDR_W = 32;

  localparam logic [12:0] DEF_CYCLE_CNT_ADDR = 13'h1004;

  typedef struct packed {
    logic                  valid;
    logic [NUM_BYTES-1:0]  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } lane_req_t;

  // Ports are big-endian, storage is little-endian.
  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < NUM_BYTES; i++) begin
      r[i*BYTE_W +: BYTE_W] = d[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  // Byte enables follow their bytes through the swap.
  function automatic logic [NUM_BYTES-1:0] mswap(input logic [NUM_BYTES-1:0] m);
    logic [NUM_BYTES-1:0] r;
    for (int i = 0; i < NUM_BYTES; i++) begin
      r[i] = m[NUM_BYTES-1-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/v_dm_bank.sv
// True dual-port, byte-write, read-first RAM bank. Port A wins a same-word write collision;
// port B's bytes are then discarded entirely.
module v_dm_bank
  import v_datamem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int ROW_W = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 a_en_i,
  input  logic [NUM_BYTES-1:0] a_we_i,
  input  logic [ROW_W-1:0]     a_addr_i,
  input  logic [DATA_W-1:0]    a_wdata_i,
  output logic [DATA_W-1:0]    a_rdata_o,
  input  logic [NUM_BYTES-1:0] b_we_i,
  input  logic [ROW_W-1:0]     b_addr_i,
  input  logic [DATA_W-1:0]    b_wdata_i,
  output logic [DATA_W-1:0]    b_rdata_o
);
  logic [NUM_BYTES-1:0][BYTE_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              b_blocked;

  assign b_blocked = a_en_i && (|a_we_i) && (a_addr_i == b_addr_i);

  always_ff @(posedge clk_i) begin
    if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
    b_rdata_q <= mem_q[b_addr_i];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (b_we_i[i] && !b_blocked) mem_q[b_addr_i][i] <= b_wdata_i[i*BYTE_W +: BYTE_W];
      if (a_en_i && a_we_i[i])     mem_q[a_addr_i][i] <= a_wdata_i[i*BYTE_W +: BYTE_W];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
endmodule

// File: rtl/v_banked_datamem.sv
// Word-interleaved multi-bank data memory: per-bank round-robin lane arbitration on port A,
// unarbitrated protocol port on port B. Define V_DATAMEM_CYCLE_CNT_EN to build the cycle counter.
module v_banked_datamem
  import v_datamem_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 2048,
  parameter int ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] CYCLE_CNT_ADDR = ADDR_W'(DEF_CYCLE_CNT_ADDR)
) (
  input  logic                        con_clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        lane_req_valid,
  input  logic [4*NUM_LANES-1:0]      lane_req_we,
  input  logic [ADDR_W*NUM_LANES-1:0] lane_req_addr,
  input  logic [32*NUM_LANES-1:0]     lane_req_wdata,
  output logic [NUM_LANES-1:0]        lane_req_ready,
  output logic [NUM_LANES-1:0]        lane_rsp_valid,
  output logic [32*NUM_LANES-1:0]     lane_rsp_rdata,
  input  logic [3:0]                  con_write,
  input  logic [ADDR_W-1:0]           con_addr,
  input  logic [31:0]                 con_in,
  output logic [31:0]                 con_out
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  lane_req_t            req      [NUM_LANES];
  logic [NUM_LANES-1:0] l_oor;
  logic [NUM_LANES-1:0] l_cnt;
  logic [BW-1:0]        l_bank   [NUM_LANES];
  logic [RW-1:0]        l_row    [NUM_LANES];

  logic [LW-1:0]        ptr_q    [NUM_BANKS];
  logic [LW-1:0]        ptr_d    [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_vld;
  logic [LW-1:0]        gnt_lane [NUM_BANKS];
  logic [NUM_LANES-1:0] bank_req [NUM_BANKS];

  logic [NUM_BYTES-1:0] a_we     [NUM_BANKS];
  logic [RW-1:0]        a_row    [NUM_BANKS];
  logic [DATA_W-1:0]    a_wdata  [NUM_BANKS];
  logic [DATA_W-1:0]    a_rdata  [NUM_BANKS];
  logic [NUM_BYTES-1:0] b_we     [NUM_BANKS];
  logic [DATA_W-1:0]    b_rdata  [NUM_BANKS];

  logic          con_oor, con_cnt;
  logic [BW-1:0] con_bank;
  logic [RW-1:0] con_row;

  logic [NUM_LANES-1:0] rsp_vld_q, rsp_oor_q, rsp_cnt_q;
  logic [BW-1:0]        rsp_bank_q [NUM_LANES];
  logic [DATA_W-1:0]    lane_rd    [NUM_LANES];
  logic                 con_live_q, con_oor_q, con_cnt_q;
  logic [BW-1:0]        con_bank_q;
  logic [DATA_W-1:0]    cnt_q, cnt_smp_q;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      req[l].valid = lane_req_valid[l];
      req[l].we    = lane_req_we[l*4 +: 4];
      req[l].addr  = REQ_ADDR_W'(lane_req_addr[l*ADDR_W +: ADDR_W]);
      req[l].wdata = lane_req_wdata[l*32 +: 32];
      l_oor[l]     = req[l].addr[ADDR_W-1];
      l_cnt[l]     = req[l].addr == REQ_ADDR_W'(CYCLE_CNT_ADDR);
      l_bank[l]    = req[l].addr[BW-1:0];
      l_row[l]     = req[l].addr[BW+RW-1:BW];
    end
  end

  assign con_oor  = con_addr[ADDR_W-1];
  assign con_cnt  = con_addr == CYCLE_CNT_ADDR;
  assign con_bank = con_addr[BW-1:0];
  assign con_row  = con_addr[BW+RW-1:BW];

  // Two passes give "first requester at or after the pointer, else wrap around".
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_vld[b]  = 1'b0;
      gnt_lane[b] = '0;
      ptr_d[b]    = ptr_q[b];
      for (int l = 0; l < NUM_LANES; l++) begin
        bank_req[b][l] = !rst && req[l].valid && !l_oor[l] && (l_bank[l] == BW'(b));
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (!gnt_vld[b] && bank_req[b][l] && (LW'(l) >= ptr_q[b])) begin
          gnt_vld[b]  = 1'b1;
          gnt_lane[b] = LW'(l);
        end
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (!gnt_vld[b] && bank_req[b][l] && (LW'(l) < ptr_q[b])) begin
          gnt_vld[b]  = 1'b1;
          gnt_lane[b] = LW'(l);
        end
      end
      if (gnt_vld[b]) begin
        ptr_d[b] = (gnt_lane[b] == LW'(NUM_LANES-1)) ? '0 : gnt_lane[b] + LW'(1);
      end
      a_we[b]    = gnt_vld[b] ? mswap(req[gnt_lane[b]].we) : '0;
      a_row[b]   = l_row[gnt_lane[b]];
      a_wdata[b] = bswap(req[gnt_lane[b]].wdata);
      b_we[b]    = (!rst && !con_oor && (con_bank == BW'(b))) ? mswap(con_write) : '0;
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_req_ready[l] = !rst && req[l].valid &&
                          (l_oor[l] || (gnt_vld[l_bank[l]] && (gnt_lane[l_bank[l]] == LW'(l))));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    v_dm_bank #(.DEPTH(BANK_DEPTH)) u_bank (
      .clk_i     (con_clk),
      .a_en_i    (gnt_vld[b]),
      .a_we_i    (a_we[b]),
      .a_addr_i  (a_row[b]),
      .a_wdata_i (a_wdata[b]),
      .a_rdata_o (a_rdata[b]),
      .b_we_i    (b_we[b]),
      .b_addr_i  (con_row),
      .b_wdata_i (bswap(con_in)),
      .b_rdata_o (b_rdata[b])
    );
  end

  always_ff @(posedge con_clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= '0;
      rsp_oor_q  <= '0;
      rsp_cnt_q  <= '0;
      con_live_q <= 1'b0;
      con_oor_q  <= 1'b0;
      con_cnt_q  <= 1'b0;
      con_bank_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) rsp_bank_q[l] <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        rsp_vld_q[l]  <= lane_req_ready[l] && (req[l].we == '0);
        rsp_oor_q[l]  <= l_oor[l];
        rsp_cnt_q[l]  <= l_cnt[l];
        rsp_bank_q[l] <= l_bank[l];
      end
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
      con_live_q <= 1'b1;
      con_oor_q  <= con_oor;
      con_cnt_q  <= con_cnt;
      con_bank_q <= con_bank;
    end
  end

`ifdef V_DATAMEM_CYCLE_CNT_EN
  // cnt_smp_q holds the count seen in the request cycle for the next-cycle response.
  always_ff @(posedge con_clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cnt_smp_q <= '0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      cnt_smp_q <= cnt_q;
    end
  end
`else
  assign cnt_q     = '0;
  assign cnt_smp_q = '0;
`endif

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_rd[l] = rsp_oor_q[l] ? (rsp_cnt_q[l] ? cnt_smp_q : '0) : bswap(a_rdata[rsp_bank_q[l]]);
      lane_rsp_rdata[l*32 +: 32] = rsp_vld_q[l] ? lane_rd[l] : '0;
    end
  end

  assign lane_rsp_valid = rsp_vld_q;
  assign con_out = !con_live_q ? '0 :
                   con_oor_q   ? (con_cnt_q ? cnt_smp_q : '0) : bswap(b_rdata[con_bank_q]);
endmodule
